// File: rtl/uart_inst_loader.sv
// Serial boot loader: UART 8N1 receiver that packs bytes little-endian into
// 32-bit words and writes them to instruction memory at incrementing addresses.
// Latency: wr_en two clocks after the stop-bit sample of the 4th byte; no backpressure (strobe only).

module uart_inst_loader #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int ADDR_W    = 8,
  parameter int IDLE_BITS = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              txd,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              loading,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;
  localparam int CNT_W    = $clog2(DIV);
  localparam int IDLE_LIM = IDLE_BITS * DIV;
  localparam int IDLE_W   = $clog2(IDLE_LIM + 1);

  localparam logic [CNT_W-1:0]  C_FULL     = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  C_HALF     = CNT_W'(HALF - 1);
  localparam logic [IDLE_W-1:0] C_IDLE_END = IDLE_W'(IDLE_LIM - 1);
  localparam logic [IDLE_W-1:0] C_IDLE_SAT = IDLE_W'(IDLE_LIM);
  localparam logic [ADDR_W-1:0] C_ADDR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_rx_prev;
  logic               w_rx;
  logic               w_fall;
  logic [CNT_W-1:0]   r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               w_tick;
  logic               w_stop_ok;
  logic               w_stop_bad;
  logic               r_byte_vld;
  logic [7:0]         r_byte;
  logic [1:0]         r_byte_idx;
  logic [23:0]        r_word;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [31:0]        r_wr_data;
  logic [ADDR_W:0]    r_word_cnt;
  logic               r_loading;
  logic               r_done;
  logic               r_frame_err;
  logic               r_got_byte;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic               w_timeout;

  assign w_rx   = r_sync2;
  assign w_fall = r_rx_prev & ~w_rx;

  // Only fires in IDLE, so it can never cut a byte in half.
  assign w_timeout = (r_state == S_IDLE) && (r_idle_cnt == C_IDLE_END) &&
                     r_got_byte && !r_done;

  // Two-flop synchronizer plus a delayed copy for start-edge detection; idle-high reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= txd;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // RX state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // RX next-state and bit-sample strobes; start edges are ignored once the load is done.
  always_comb begin
    w_next     = r_state;
    w_tick     = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !r_done) w_next = S_START;
      end
      S_START: begin
        if (r_clk_cnt == C_HALF) begin
          w_tick = 1'b1;
          w_next = w_rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == C_FULL) begin
          w_tick = 1'b1;
          if (r_bit_idx == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == C_FULL) begin
          w_tick     = 1'b1;
          w_next     = S_IDLE;
          w_stop_ok  = w_rx;
          w_stop_bad = ~w_rx;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bit-period counter: held at zero in IDLE, restarts on every sample strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            r_clk_cnt <= '0;
    else if (r_state == S_IDLE || w_tick)   r_clk_cnt <= '0;
    else                                    r_clk_cnt <= r_clk_cnt + 1'b1;
  end

  // Data-bit shifter, LSB first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (r_state == S_START) begin
      r_bit_idx <= '0;
    end else if (r_state == S_DATA && w_tick) begin
      r_shift   <= {w_rx, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  // Registered byte-valid pulse; bytes arriving after done never get here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_byte_vld <= w_stop_ok && !r_done;
      if (w_stop_ok) r_byte <= r_shift;
    end
  end

  // Idle timer: cleared outside IDLE, saturates so it cannot wrap and re-fire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      r_idle_cnt <= '0;
    else if (r_state != S_IDLE)       r_idle_cnt <= '0;
    else if (r_idle_cnt != C_IDLE_SAT) r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  // Sticky framing error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         r_frame_err <= 1'b0;
    else if (w_stop_bad) r_frame_err <= 1'b1;
  end

  // Word assembly, write strobe, address/count advance and load completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_byte_idx <= '0;
      r_word     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_word_cnt <= '0;
      r_loading  <= 1'b0;
      r_done     <= 1'b0;
      r_got_byte <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      // loading rises together with the byte-valid pulse
      if (w_stop_ok && !r_done) r_loading <= 1'b1;
      if (r_byte_vld && !r_done) begin
        r_got_byte <= 1'b1;
        case (r_byte_idx)
          2'd0: r_word[7:0]   <= r_byte;
          2'd1: r_word[15:8]  <= r_byte;
          2'd2: r_word[23:16] <= r_byte;
          default: begin
            r_wr_data <= {r_byte, r_word};
            r_wr_en   <= 1'b1;
          end
        endcase
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      // advance after the strobe so wr_addr is stable while wr_en is high
      if (r_wr_en) begin
        r_word_cnt <= r_word_cnt + 1'b1;
        if (r_wr_addr == C_ADDR_MAX) begin
          r_done    <= 1'b1;
          r_loading <= 1'b0;
        end else begin
          r_wr_addr <= r_wr_addr + 1'b1;
        end
      end
      // a partial word is simply abandoned
      if (w_timeout) begin
        r_done     <= 1'b1;
        r_loading  <= 1'b0;
        r_byte_idx <= '0;
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign loading   = r_loading;
  assign done      = r_done;
  assign frame_err = r_frame_err;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Bench for uart_inst_loader: serial byte stimulus against a list-level model
// of the expected memory writes and status flags.
// Small configuration: DIV=16, 4-word memory, 64-clock idle timeout.

module tb_uart_inst_loader;

  localparam int CLK_FREQ  = 1600;
  localparam int BAUD      = 100;
  localparam int ADDR_W    = 2;
  localparam int IDLE_BITS = 4;
  localparam int DIV       = CLK_FREQ / BAUD;
  localparam int WORDS     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              txd = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              loading;
  logic              done;
  logic              frame_err;
  logic [ADDR_W:0]   word_cnt;

  uart_inst_loader #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ADDR_W   (ADDR_W),
    .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .txd      (txd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .loading  (loading),
    .done     (done),
    .frame_err(frame_err),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every strobe and counts strobes longer than one clock.
  logic [ADDR_W+31:0] act_q[$];
  int   wide_cnt = 0;
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      act_q.push_back({wr_addr, wr_data});
      if (prev_we === 1'b1) wide_cnt++;
    end
    prev_we = wr_en;
  end

  // Reference model: accepted bytes are grouped four at a time into words.
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] m_word;
  int m_nb, m_words;
  bit m_any, m_done, m_ferr;

  task automatic m_reset();
    exp_q.delete();
    m_word = '0; m_nb = 0; m_words = 0;
    m_any = 0; m_done = 0; m_ferr = 0;
  endtask

  task automatic m_byte(input logic [7:0] b, input bit good);
    if (m_done) return;
    if (!good) begin
      m_ferr = 1;
      return;
    end
    m_any = 1;
    m_word[m_nb*8 +: 8] = b;
    m_nb++;
    if (m_nb == 4) begin
      exp_q.push_back({m_words[ADDR_W-1:0], m_word});
      m_words++;
      m_nb = 0;
      if (m_words == WORDS) m_done = 1;
    end
  endtask

  task automatic m_idle();
    if (m_any) m_done = 1;
  endtask

  // Serial driver; always called and returns on a falling clock edge.
  task automatic drive_bit(input logic v);
    txd = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    txd = 1'b1;
    repeat (gap) @(negedge clk);
    m_byte(b, stop_ok);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    txd = 1'b1;
    repeat (3) @(negedge clk);
    m_reset();
    act_q.delete();
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nwr"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
    check({tag, "_word_cnt"}, 64'(word_cnt), 64'(m_words));
    check({tag, "_done"}, 64'(done), 64'(m_done));
    check({tag, "_loading"}, 64'(loading), 64'(m_any && !m_done));
    check({tag, "_frame_err"}, 64'(frame_err), 64'(m_ferr));
    check({tag, "_we_width"}, 64'(wide_cnt), 64'd0);
  endtask

  logic [7:0] b;
  bit good;
  int n, gap;

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_outs", 64'({wr_addr, wr_data, loading, done, frame_err, word_cnt}), 64'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // one full word, then idle timeout
    send_byte(8'h13, 1, DIV);
    send_byte(8'h00, 1, DIV);
    send_byte(8'h20, 1, DIV);
    send_byte(8'h24, 1, DIV);
    check("t1_nwr", 64'(act_q.size()), 64'd1);
    if (act_q.size() >= 1) check("t1_word", 64'(act_q[0]), {30'd0, 2'd0, 32'h24200013});
    check("t1_pre_done", 64'(done), 64'd0);
    check("t1_pre_loading", 64'(loading), 64'd1);
    compare_all("t1_pre");
    repeat (120) @(negedge clk);
    m_idle();
    compare_all("t1");

    // framing error on the first byte; the bad byte is not part of the word
    do_reset();
    send_byte(8'h55, 0, DIV);
    send_byte(8'hAA, 1, DIV);
    send_byte(8'hBB, 1, DIV);
    send_byte(8'hCC, 1, DIV);
    send_byte(8'hDD, 1, DIV);
    if (act_q.size() >= 1) check("t2_word", 64'(act_q[0]), {30'd0, 2'd0, 32'hDDCCBBAA});
    compare_all("t2");

    // short low glitch on an idle line
    do_reset();
    txd = 1'b0;
    repeat (5) @(negedge clk);
    txd = 1'b1;
    repeat (200) @(negedge clk);
    compare_all("t3");

    // 5 words into a 4-word memory
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1, DIV);
    check("t4_done_at_full", 64'(done), 64'd1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1, DIV);
    compare_all("t4");

    // trailing partial word dropped on timeout
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1, DIV);
    compare_all("t5_pre");
    repeat (120) @(negedge clk);
    m_idle();
    compare_all("t5");

    // reset during data bit 4 of the third byte
    do_reset();
    for (int i = 0; i < 2; i++) send_byte(8'($urandom), 1, DIV);
    b = 8'($urandom);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    txd = b[4];
    repeat (DIV / 2) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_in_rst", 64'({wr_en, loading, done, word_cnt}), 64'd0);
    txd = 1'b1;
    m_reset();
    act_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    compare_all("t6_rel");
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1, DIV);
    compare_all("t6");

    // randomized byte streams with occasional framing errors
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(1, 22);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        good = ($urandom_range(0, 7) != 0);
        gap = $urandom_range(good ? 0 : 1, 2) * DIV + $urandom_range(0, 7);
        send_byte(b, good, gap);
      end
      repeat (120) @(negedge clk);
      m_idle();
      compare_all($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
